// File: rtl/beat_mode_ctrl.sv
// beat_mode_ctrl: multi-track free/record/play/overdub mode FSM and tick-driven RAM address counter with per-track lengths
module beat_mode_ctrl #(
  parameter int NUM_TRACKS = 4,
  parameter int ADDR_W     = 10,
  parameter int TRK_W      = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  sw_rec,
  input  logic                  sw_play,
  input  logic                  sw_dub,
  input  logic [TRK_W-1:0]      track_sel,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic [NUM_TRACKS-1:0] ram_we,
  output logic                  ram_re,
  output logic [1:0]            out_src,
  output logic [TRK_W-1:0]      active_trk,
  output logic [1:0]            state_code,
  output logic                  loop_pulse,
  output logic                  rec_full
);
  typedef enum logic [1:0] {FREE = 2'b00, REC = 2'b01, PLAY = 2'b10, DUB = 2'b11} state_t;
  localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};
  state_t state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TRK_W-1:0] trk_q, trk_d;
  logic [ADDR_W:0] len_q [NUM_TRACKS];
  logic [ADDR_W:0] len_d [NUM_TRACKS];
  logic full_q, full_d, loop_q, loop_d;
  logic [ADDR_W:0] sel_len, act_len;
  logic at_max, at_end, wr;
  always_comb begin
    sel_len = len_q[track_sel];
    act_len = len_q[trk_q];
    at_max  = addr_q == '1;
    at_end  = {1'b0, addr_q} == act_len - (ADDR_W+1)'(1);
    wr      = tick && ((state_q == REC && !full_q) || state_q == DUB);
  end
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    trk_d   = trk_q;
    len_d   = len_q;
    full_d  = 1'b0;
    loop_d  = 1'b0;
    case (state_q)
      FREE: begin
        state_d = sw_rec ? REC :
                  sw_play ? ((sel_len != '0) ? PLAY : FREE) :
                  (sw_dub && sel_len != '0) ? DUB : FREE;
        if (state_d != FREE) begin
          trk_d  = track_sel;
          addr_d = '0;
        end
      end
      REC: begin
        full_d = full_q || (tick && at_max);
        if (tick && !at_max) addr_d = addr_q + 1'b1;
        if (!sw_rec) begin
          len_d[trk_q] = full_d ? CAP : {1'b0, addr_d};
          state_d      = FREE;
          full_d       = 1'b0;
        end
      end
      default: begin
        if (tick) begin
          addr_d = at_end ? '0 : addr_q + 1'b1;
          loop_d = at_end;
        end
        state_d = ((state_q == PLAY) ? sw_play : sw_dub) ? state_q : FREE;
      end
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FREE;
      addr_q  <= '0;
      trk_q   <= '0;
      len_q   <= '{default: '0};
      full_q  <= 1'b0;
      loop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      trk_q   <= trk_d;
      len_q   <= len_d;
      full_q  <= full_d;
      loop_q  <= loop_d;
    end
  end
  assign ram_addr   = addr_q;
  assign ram_we     = wr ? (NUM_TRACKS'(1) << trk_q) : '0;
  assign ram_re     = state_q[1];
  assign out_src    = (state_q == FREE) ? 2'b00 : (state_q == PLAY) ? 2'b01 : 2'b10;
  assign active_trk = trk_q;
  assign state_code = state_q;
  assign loop_pulse = loop_q;
  assign rec_full   = full_q;
endmodule
